seg7_result_scan: RTL and testbench

- Display-side consumer of the CPU memory-mapped result register.
- Takes the 32-bit value driven by the data-memory block's `result` output and time-multiplexes it as 8 hex digits onto a common-anode 7-segment array.
- Samples the value only at frame boundaries, so a CPU store mid-scan never produces a torn display.
- Sits at the board top, between the data-memory block and the display pins.

---
 rtl/seg7_result_scan.sv | 126 ++++++++++++
 tb/tb_seg7_result_scan.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seg7_result_scan.sv
// seg7_result_scan
//
// Shows the CPU result register as 8 hex digits on a common-anode 7-segment array.
// The digits are time-multiplexed. The value is captured into a shadow register only
// at the frame wrap, so a store that lands mid-scan never tears the displayed value.
//
// Parameters:
//   CLK_DIV     clk cycles per digit slot (>= 2)
//
// Ports:
//   clk         system clock, posedge
//   rst_n       asynchronous active-low reset
//   result      value to display; digit k shows result[4k+3:4k]
//   hold        1 = keep the current shadow at the frame wrap
//   an          digit anodes, active-low, one-hot-low while scanning
//   seg         {dp,g,f,e,d,c,b,a}, active-low, dp always off
//   frame_done  one-cycle pulse when digit 0 of a new frame is lit
//
// Optional build macro:
//   SEG7_LEADING_ZERO_BLANK_EN  blanks leading-zero digits (digit 0 is never blanked)

module seg7_result_scan #(
    parameter int unsigned CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] result,
    input  logic        hold,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [31:0]     shadow_q, shadow_d;
    logic [7:0]      an_q, an_d;
    logic [7:0]      seg_q, seg_d;
    logic            fd_q, fd_d;

    logic            tick;
    logic [31:0]     shown_sh;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    assign tick = (cnt_q == CntMax);

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        an_d     = an_q;
        seg_d    = seg_q;
        fd_d     = 1'b0;
        shown_sh = '0;

        if (tick) begin
            // idx 7 wraps to 0 naturally in 3 bits
            idx_d = idx_q + 3'd1;
            an_d  = ~(8'h01 << idx_d);
            if (idx_q == 3'd7) begin
                fd_d = 1'b1;
                if (!hold) begin
                    shadow_d = result;
                end
            end
            // shadow_d is the value this frame shows, including a fresh sample at the wrap
            shown_sh = shadow_d >> {idx_d, 2'b00};
            seg_d    = {1'b1, hex7(shown_sh[3:0])};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            // Digit k is blank when nibbles k..7 are all zero; anode stays on for even timing
            if (idx_d != 3'd0 && shown_sh == 32'h0) begin
                seg_d = 8'hFF;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= 3'd7;
            shadow_q <= 32'h0;
            an_q     <= 8'hFF;
            seg_q    <= 8'hFF;
            fd_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            fd_q     <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_result_scan.sv
// Directed bench for seg7_result_scan with CLK_DIV=4 (one digit slot = 4 clocks,
// one frame = 32 clocks). Inputs change and outputs are sampled on the falling edge.

module tb_seg7_result_scan;

    logic        clk;
    logic        rst_n;
    logic [31:0] result;
    logic        hold;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    int nvec;
    int nerr;
    int fd_cnt;

    logic [7:0] glyph [16];

    seg7_result_scan #(
        .CLK_DIV(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .result    (result),
        .hold      (hold),
        .an        (an),
        .seg       (seg),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] an_e, input logic [7:0] seg_e,
                       input logic fd_e);
        nvec++;
        assert (an === an_e && seg === seg_e && frame_done === fd_e) else begin
            nerr++;
            $error("FAIL %s: an/seg/fd got %h/%h/%b required %h/%h/%b",
                   tag, an, seg, frame_done, an_e, seg_e, fd_e);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: got %0d required %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] an_of(input int k);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << k);
    endfunction

    // Expected seg for slot k when value v is on display.
    function automatic logic [7:0] exp_seg(input logic [31:0] v, input int k);
        logic [31:0] s;
        logic [7:0]  r;
        s = v >> (4 * k);
        r = glyph[s[3:0]];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (k >= 1 && s == 32'h0) r = 8'hFF;
`endif
        return r;
    endfunction

    initial begin
        nvec = 0;
        nerr = 0;
        glyph[0]  = 8'hC0; glyph[1]  = 8'hF9; glyph[2]  = 8'hA4; glyph[3]  = 8'hB0;
        glyph[4]  = 8'h99; glyph[5]  = 8'h92; glyph[6]  = 8'h82; glyph[7]  = 8'hF8;
        glyph[8]  = 8'h80; glyph[9]  = 8'h90; glyph[10] = 8'h88; glyph[11] = 8'h83;
        glyph[12] = 8'hC6; glyph[13] = 8'hA1; glyph[14] = 8'h86; glyph[15] = 8'h8E;

        rst_n  = 1'b0;
        hold   = 1'b0;
        result = 32'h12345678;
        wait_neg(3);
        chk("reset", 8'hFF, 8'hFF, 1'b0);

        // First tick lands on the 4th rising edge after release
        rst_n = 1'b1;
        wait_neg(3);
        chk("pre_tick", 8'hFF, 8'hFF, 1'b0);
        wait_neg(1);
        chk("f1_d0", 8'hFE, 8'h80, 1'b1);

        // Frame 1: 12345678; result changes while idx=3 and must not show until the wrap
        for (int k = 1; k < 8; k++) begin
            wait_neg(4);
            chk($sformatf("f1_d%0d", k), an_of(k), exp_seg(32'h12345678, k), 1'b0);
            if (k == 3) result = 32'hDEADBEEF;
        end
        wait_neg(4);
        chk("f2_wrap", 8'hFE, 8'h8E, 1'b1);

        // Frame 2: DEADBEEF, frame_done once per 32 cycles
        fd_cnt = 0;
        for (int i = 1; i <= 32; i++) begin
            wait_neg(1);
            if (frame_done === 1'b1) fd_cnt++;
            if (i % 4 == 0)
                chk($sformatf("f2_d%0d", (i / 4) % 8), an_of((i / 4) % 8),
                    exp_seg(32'hDEADBEEF, (i / 4) % 8), (i == 32));
        end
        chk_int("fd_per_frame", fd_cnt, 1);

        // Hold across a wrap with result cleared
        hold   = 1'b1;
        result = 32'h0;
        wait_neg(4);
        chk("hold_d1", 8'hFD, 8'h86, 1'b0);
        wait_neg(28);
        chk("hold_wrap", 8'hFE, 8'h8E, 1'b1);
        hold = 1'b0;
        wait_neg(32);
        chk("zero_wrap", 8'hFE, 8'hC0, 1'b1);
        wait_neg(4);
        chk("zero_d1", 8'hFD, exp_seg(32'h0, 1), 1'b0);

        // Leading-zero case 000000A5
        result = 32'h000000A5;
        wait_neg(28);
        chk("a5_d0", 8'hFE, 8'h92, 1'b1);
        wait_neg(4);
        chk("a5_d1", 8'hFD, 8'h88, 1'b0);
        for (int k = 2; k < 8; k++) begin
            wait_neg(4);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            chk($sformatf("a5_d%0d", k), an_of(k), 8'hFF, 1'b0);
`else
            chk($sformatf("a5_d%0d", k), an_of(k), 8'hC0, 1'b0);
`endif
        end

        // Async reset in the middle of slot 5
        wait_neg(24);
        chk("pre_rst_d5", 8'hDF, exp_seg(32'h000000A5, 5), 1'b0);
        wait_neg(2);
        rst_n = 1'b0;
        #1;
        chk("async_rst", 8'hFF, 8'hFF, 1'b0);
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(3);
        chk("rst2_pre_tick", 8'hFF, 8'hFF, 1'b0);
        wait_neg(1);
        chk("rst2_d0", 8'hFE, 8'h92, 1'b1);
        wait_neg(4);
        chk("rst2_d1", 8'hFD, 8'h88, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
